dbg_bus_master: RTL and testbench

DBG_BUS_MASTER -- requirements
Module: dbg_bus_master

---
 rtl/dbg_pkg.sv | 23 ++
 rtl/dbg_gap_timer.sv | 27 ++
 rtl/dbg_bus_master.sv | 159 +++++++++++++++
 tb/tb_dbg_bus_master.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared opcodes and FSM state encoding for the debug bus master
package dbg_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_REQ      = 3'd3,
        ST_ACCESS   = 3'd4,
        ST_SEND     = 3'd5
    } state_t;

    // Select byte lane k (0 = least significant) of a 32-bit word.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        logic [31:0] shifted;
        shifted = word >> {k, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/dbg_gap_timer.sv
// rtl/dbg_gap_timer.sv - inter-byte idle gap counter with expire flag
module dbg_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    logic [31:0] count;

    // Count idle cycles while parsing; any received byte or leaving the parse states restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (!run || clear) begin
            count <= 32'd0;
        end else if (!expire) begin
            count <= count + 32'd1;
        end
    end

    assign expire = run && (count >= TIMEOUT_CYCLES);

endmodule

// File: rtl/dbg_bus_master.sv
// rtl/dbg_bus_master.sv - UART byte-command parser driving single bridge bus accesses
module dbg_bus_master
    import dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B
) (
    input  logic        clk,
    input  logic        sys_rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [31:0] Addr,
    output logic [31:0] WD,
    output logic        WE,
    output logic [3:0]  ByteEN,
    input  logic [31:0] RD,
    output logic        busy
);

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_cnt;
    logic        byte_step;
    logic        is_write;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] rd_q;
    logic [31:0] addr_out;
    logic [31:0] wd_out;
    logic        parsing;
    logic        gap_expire;
    logic        op_ok;

    assign parsing = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
    assign op_ok   = rx_valid && ((rx_data == OP_WRITE) || (rx_data == OP_READ));

    dbg_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk   (clk),
        .rst_n (sys_rstn),
        .run   (parsing),
        .clear (rx_valid),
        .expire(gap_expire)
    );

    // State register plus byte counter, assembled command words and bus-side holding registers.
    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state    <= ST_IDLE;
            byte_cnt <= 2'd0;
            is_write <= 1'b0;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            rd_q     <= 32'd0;
            addr_out <= 32'd0;
            wd_out   <= 32'd0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                byte_cnt <= 2'd0;
            end else if (byte_step) begin
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == ST_IDLE && op_ok) begin
                is_write <= (rx_data == OP_WRITE);
            end
            if (state == ST_GET_ADDR && rx_valid) begin
                addr_q[{byte_cnt, 3'b000} +: 8] <= rx_data;
            end
            if (state == ST_GET_DATA && rx_valid) begin
                data_q[{byte_cnt, 3'b000} +: 8] <= rx_data;
            end
            // Bus address/data only change on entry to ACCESS so they hold between accesses.
            if (state == ST_REQ && bus_gnt) begin
                addr_out <= addr_q;
                if (is_write) begin
                    wd_out <= data_q;
                end
            end
            if (state == ST_ACCESS && !is_write) begin
                rd_q <= RD;
            end
        end
    end

    // Next-state logic; bytes arriving outside IDLE/GET_* fall through untouched.
    always_comb begin
        state_next = state;
        byte_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_ok) begin
                    state_next = ST_GET_ADDR;
                end
            end
            ST_GET_ADDR: begin
                if (rx_valid) begin
                    byte_step = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        state_next = is_write ? ST_GET_DATA : ST_REQ;
                    end
                end else if (gap_expire) begin
                    state_next = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (rx_valid) begin
                    byte_step = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        state_next = ST_REQ;
                    end
                end else if (gap_expire) begin
                    state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    byte_step = 1'b1;
                    if (is_write || byte_cnt == 2'd3) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state so reset forces them to their idle values immediately.
    always_comb begin
        bus_req  = (state == ST_REQ) || (state == ST_ACCESS);
        WE       = (state == ST_ACCESS) && is_write;
        ByteEN   = (state == ST_ACCESS) ? 4'b1111 : 4'b0000;
        busy     = (state != ST_IDLE);
        tx_valid = (state == ST_SEND);
        tx_data  = 8'h00;
        if (state == ST_SEND) begin
            tx_data = is_write ? ACK_BYTE : byte_lane(rd_q, byte_cnt);
        end
        Addr = addr_out;
        WD   = wd_out;
    end

endmodule

// File: tb/tb_dbg_bus_master.sv
// tb/tb_dbg_bus_master.sv - randomized self-checking bench for dbg_bus_master
module tb_dbg_bus_master;

    localparam logic [31:0] RD_KEY = 32'h5A5AC3C3;
    localparam logic [7:0]  ACK    = 8'h4B;

    logic        clk;
    logic        sys_rstn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic        WE;
    logic [3:0]  ByteEN;
    logic [31:0] RD;
    logic        busy;

    int          n_checks;
    int          n_fail;

    int          gnt_delay;
    bit          gnt_pulse;
    bit          gnt_block;
    int          ready_mode;
    bit          rd_ovr_en;
    logic [31:0] rd_ovr;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
    } acc_t;

    acc_t       acc_q[$];
    logic [7:0] tx_q[$];

    dbg_bus_master #(
        .TIMEOUT_CYCLES(16),
        .ACK_BYTE      (ACK)
    ) dut (
        .clk     (clk),
        .sys_rstn(sys_rstn),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .bus_req (bus_req),
        .bus_gnt (bus_gnt),
        .Addr    (Addr),
        .WD      (WD),
        .WE      (WE),
        .ByteEN  (ByteEN),
        .RD      (RD),
        .busy    (busy)
    );

    // Bus slave: read data is a fixed function of the address unless overridden.
    assign RD = rd_ovr_en ? rd_ovr : (Addr ^ RD_KEY);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Arbiter model: grant gnt_delay cycles after request, optionally only for one cycle.
    initial begin
        int cnt;
        bus_gnt = 1'b0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus_req || gnt_block) begin
                bus_gnt = 1'b0;
                cnt = 0;
            end else if (gnt_pulse && bus_gnt) begin
                bus_gnt = 1'b0;
            end else if (cnt >= gnt_delay) begin
                bus_gnt = 1'b1;
            end else begin
                cnt++;
            end
        end
    end

    // Transmitter model: always ready, random, or 5 cycles busy per byte.
    initial begin
        int rcnt;
        tx_ready = 1'b1;
        rcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: tx_ready = 1'($urandom_range(0, 1));
                2: begin
                    tx_ready = (rcnt == 5);
                    rcnt = (rcnt == 5) ? 0 : rcnt + 1;
                end
                default: tx_ready = 1'b1;
            endcase
        end
    end

    // Monitor at the falling edge: log accesses and accepted bytes, check tx hold stability.
    initial begin
        bit         prev_hold;
        logic [7:0] prev_d;
        prev_hold = 1'b0;
        prev_d = 8'h00;
        forever begin
            @(negedge clk);
            if (sys_rstn) begin
                if (ByteEN == 4'hF) acc_q.push_back({Addr, WD, WE});
                if (WE && ByteEN != 4'hF) check("we_outside_access", {28'd0, ByteEN}, 32'hF);
                if (tx_valid && tx_ready) tx_q.push_back(tx_data);
                if (prev_hold) begin
                    check("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
                    check("tx_hold_data", {24'd0, tx_data}, {24'd0, prev_d});
                end
                prev_hold = tx_valid && !tx_ready;
                prev_d = tx_data;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Send one command, wait for completion, and compare against the expected transaction.
    task automatic run_cmd(input bit is_w, input logic [31:0] a, input logic [31:0] d, input bit inject);
        logic [7:0]  b[9];
        int          n;
        bit          done;
        logic [31:0] exp_rd;
        logic [31:0] sh;
        int          nexp;
        logic [7:0]  exp_tx[4];
        acc_t        got;

        b[0] = is_w ? 8'h57 : 8'h52;
        for (int i = 0; i < 4; i++) begin
            sh = a >> (8 * i);
            b[1 + i] = sh[7:0];
            sh = d >> (8 * i);
            b[5 + i] = sh[7:0];
        end
        n = is_w ? 9 : 5;
        for (int i = 0; i < n; i++) begin
            send_byte(b[i]);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end

        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                done = 1'b1;
                rx_valid = 1'b0;
                break;
            end
            if (inject && tx_valid) begin
                rx_data = 8'($urandom);
                rx_valid = 1'($urandom_range(0, 1));
            end else begin
                rx_valid = 1'b0;
            end
        end
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        check("cmd_done", {31'd0, done}, 32'd1);

        exp_rd = rd_ovr_en ? rd_ovr : (a ^ RD_KEY);
        if (is_w) begin
            nexp = 1;
            exp_tx[0] = ACK;
        end else begin
            nexp = 4;
            for (int i = 0; i < 4; i++) begin
                sh = exp_rd >> (8 * i);
                exp_tx[i] = sh[7:0];
            end
        end

        check("access_count", acc_q.size(), 32'd1);
        if (acc_q.size() > 0) begin
            got = acc_q[0];
            check("access_addr", got.addr, a);
            check("access_we", {31'd0, got.we}, {31'd0, is_w});
            if (is_w) check("access_wd", got.wd, d);
        end
        check("tx_count", tx_q.size(), nexp);
        for (int i = 0; i < nexp && i < tx_q.size(); i++) begin
            check("tx_byte", {24'd0, tx_q[i]}, {24'd0, exp_tx[i]});
        end
        acc_q.delete();
        tx_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
        check({tag, "_we"}, {31'd0, WE}, 32'd0);
        check({tag, "_byteen"}, {28'd0, ByteEN}, 32'd0);
        check({tag, "_addr"}, Addr, 32'd0);
        check({tag, "_wd"}, WD, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit          req_seen;
        logic [7:0]  junk;
        n_checks = 0;
        n_fail = 0;
        gnt_delay = 3;
        gnt_pulse = 1'b0;
        gnt_block = 1'b0;
        ready_mode = 0;
        rd_ovr_en = 1'b0;
        rd_ovr = 32'd0;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        sys_rstn = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        sys_rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Directed write with grant 3 cycles after request.
        run_cmd(1'b1, 32'h00000010, 32'hDEADBEEF, 1'b0);

        // Directed read with fixed read data and a slow transmitter.
        rd_ovr_en = 1'b1;
        rd_ovr = 32'h12345678;
        ready_mode = 2;
        run_cmd(1'b0, 32'h00000010, 32'd0, 1'b0);
        rd_ovr_en = 1'b0;
        ready_mode = 0;

        // Unknown opcode in IDLE is discarded.
        send_byte(8'h41);
        check("bad_op_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("bad_op_busy_later", {31'd0, busy}, 32'd0);
        check("bad_op_tx", tx_q.size(), 32'd0);

        // Truncated write times out without an access, then a read works.
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'h00);
        repeat (40) @(posedge clk);
        #1;
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_access", acc_q.size(), 32'd0);
        check("timeout_tx", tx_q.size(), 32'd0);
        run_cmd(1'b0, 32'hCAFE0003, 32'd0, 1'b0);

        // Bytes injected while responding are ignored.
        ready_mode = 1;
        run_cmd(1'b0, 32'($urandom), 32'd0, 1'b1);
        run_cmd(1'b1, 32'($urandom), 32'($urandom), 1'b1);

        // Randomized commands with varying grant, ready and injection behaviour.
        for (int it = 0; it < 20; it++) begin
            gnt_delay = $urandom_range(0, 4);
            gnt_pulse = 1'($urandom_range(0, 1));
            ready_mode = $urandom_range(0, 1);
            if ($urandom_range(0, 2) == 0) begin
                junk = 8'($urandom);
                if (junk == 8'h57 || junk == 8'h52) junk = 8'h00;
                send_byte(junk);
            end
            run_cmd(1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset while requesting the bus aborts with no access.
        gnt_pulse = 1'b0;
        ready_mode = 0;
        gnt_block = 1'b1;
        send_byte(8'h57);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        req_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus_req) begin
                req_seen = 1'b1;
                break;
            end
        end
        check("req_seen", {31'd0, req_seen}, 32'd1);
        #2;
        sys_rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        sys_rstn = 1'b1;
        gnt_block = 1'b0;
        repeat (3) @(posedge clk);
        check("midreset_access", acc_q.size(), 32'd0);
        check("midreset_tx", tx_q.size(), 32'd0);
        gnt_delay = 1;
        run_cmd(1'b1, 32'h00000007, 32'h0BADF00D, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
